// File: rtl/cdc_avg_rx.sv
// Receive side of a 4-phase req/ack link: synchronises req, captures one sample per
// handshake and produces the floor average of N = 2^LOG2N samples (block or sliding window).
module cdc_avg_rx #(
  parameter int DW          = 4,
  parameter int LOG2N       = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_2,
  input  logic             reset,
  input  logic             req,
  input  logic [DW-1:0]    data,
  input  logic             mode,
  output logic             ack,
  output logic [DW-1:0]    avg,
  output logic             avg_valid,
  output logic [LOG2N:0]   fill_cnt
);

  localparam int N  = 1 << LOG2N;
  localparam int AW = DW + LOG2N;
  localparam logic [LOG2N:0] N_F = (LOG2N + 1)'(N);

  typedef enum logic [1:0] {
    WAIT_LOW = 2'd0,
    WAIT_REQ = 2'd1,
    WAIT_REL = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic                 ack_q, ack_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_vld_q;
  logic                 req_s, sync_ok, capture;
  logic                 mode_q, mode_chg;
  logic [AW-1:0]        acc_q, acc_d, acc_base, acc_sum;
  logic [LOG2N:0]       fill_q, fill_d, fill_base, fill_inc;
  logic [LOG2N-1:0]     wp_q, wp_d, wp_base;
  logic [DW-1:0]        avg_q, avg_d, old_sample;
  logic                 valid_q, valid_d, buf_we;
  logic [DW-1:0]        buf_q [N];

  // sync_vld_q marks when the synchroniser has been refilled with real req samples
  // after reset, so WAIT_LOW cannot mistake the cleared flops for a released req.
  always_ff @(posedge clk_2) begin
    if (reset) begin
      sync_q     <= '0;
      sync_vld_q <= '0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], req};
      sync_vld_q <= {sync_vld_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign req_s   = sync_q[SYNC_STAGES-1];
  assign sync_ok = sync_vld_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    capture = 1'b0;
    case (state_q)
      WAIT_LOW: if (sync_ok && !req_s) state_d = WAIT_REQ;
      WAIT_REQ: begin
        if (req_s) begin
          capture = 1'b1;
          ack_d   = 1'b1;
          state_d = WAIT_REL;
        end
      end
      WAIT_REL: begin
        if (req_s) ack_d = 1'b1;
        else       state_d = WAIT_REQ;
      end
      default:  state_d = WAIT_LOW;
    endcase
  end

  // A mode change restarts the group/window; a capture on that edge is its first sample.
  // Slots at or beyond fill_cnt are logically empty, so the outgoing sample is gated
  // to zero until the window is full and the array itself never needs clearing.
  always_comb begin
    mode_chg   = (mode != mode_q);
    acc_base   = mode_chg ? '0 : acc_q;
    fill_base  = mode_chg ? '0 : fill_q;
    wp_base    = mode_chg ? '0 : wp_q;
    old_sample = (fill_base == N_F) ? buf_q[wp_base] : '0;
    acc_sum    = acc_base + AW'(data) - (mode ? AW'(old_sample) : '0);
    fill_inc   = fill_base + (LOG2N + 1)'(1);
    acc_d      = acc_base;
    fill_d     = fill_base;
    wp_d       = wp_base;
    avg_d      = avg_q;
    valid_d    = 1'b0;
    buf_we     = 1'b0;
    if (capture) begin
      if (!mode) begin
        if (fill_inc == N_F) begin
          avg_d   = acc_sum[AW-1:LOG2N];
          valid_d = 1'b1;
          acc_d   = '0;
          fill_d  = '0;
        end else begin
          acc_d  = acc_sum;
          fill_d = fill_inc;
        end
      end else begin
        acc_d  = acc_sum;
        buf_we = 1'b1;
        wp_d   = wp_base + LOG2N'(1);
        fill_d = (fill_base == N_F) ? fill_base : fill_inc;
        if (fill_d == N_F) begin
          avg_d   = acc_sum[AW-1:LOG2N];
          valid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_2) begin
    if (reset) begin
      state_q <= WAIT_LOW;
      ack_q   <= 1'b0;
      mode_q  <= mode;
      acc_q   <= '0;
      fill_q  <= '0;
      wp_q    <= '0;
      avg_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      mode_q  <= mode;
      acc_q   <= acc_d;
      fill_q  <= fill_d;
      wp_q    <= wp_d;
      avg_q   <= avg_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk_2) begin
    if (buf_we) buf_q[wp_base] <= data;
  end

  assign ack       = ack_q;
  assign avg       = avg_q;
  assign avg_valid = valid_q;
  assign fill_cnt  = fill_q;

endmodule
